iq_issue_sched: RTL and testbench

- Issue scheduler for the collapsing fifo_ram issue queue: index 0 is the oldest entry, and entries collapse on dequeue.
- Each cycle it tracks source-operand readiness by comparing wakeup tags against each entry's sources. It writes newly set ready bits back through the per-entry write ports.
- It selects the oldest fully-ready entry and drives the dequeue one-hot and handshake toward a single shared functional unit (FU).
- The FU is either pipelined or non-pipelined with variable latency. For non-pipelined ops the scheduler holds a busy countdown and produces the result-ready wakeup for the issued destination tag.

---
 rtl/iq_issue_sched.sv | 139 +++++++++++++
 tb/tb_iq_issue_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_issue_sched.sv
// Issue scheduler for a collapsing issue queue (index 0 = oldest).
// Tracks operand wakeups, writes back new ready bits, picks the oldest
// fully-ready entry for a single shared FU and generates the result wakeup
// for multi-cycle (non-pipelined) ops.
module iq_issue_sched #(
   parameter int unsigned N_ENTRIES = 8,
   parameter int unsigned TAG_WIDTH = 6,
   parameter int unsigned N_WAKEUP  = 2,
   parameter int unsigned LAT_WIDTH = 3,
   parameter int unsigned CTR_WIDTH = $clog2(N_ENTRIES) + 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic [CTR_WIDTH-1:0]           entry_count,
   input  logic [N_ENTRIES*TAG_WIDTH-1:0] entry_src1_tag,
   input  logic [N_ENTRIES*TAG_WIDTH-1:0] entry_src2_tag,
   input  logic [N_ENTRIES-1:0]           entry_src1_rdy,
   input  logic [N_ENTRIES-1:0]           entry_src2_rdy,
   input  logic [N_ENTRIES*TAG_WIDTH-1:0] entry_dst_tag,
   input  logic [N_ENTRIES*LAT_WIDTH-1:0] entry_lat,
   input  logic [N_WAKEUP-1:0]            wakeup_valid,
   input  logic [N_WAKEUP*TAG_WIDTH-1:0]  wakeup_tag,
   input  logic                           fu_ready,
   output logic [N_ENTRIES-1:0]           rdy_wr_en,
   output logic [N_ENTRIES-1:0]           set_src1_rdy,
   output logic [N_ENTRIES-1:0]           set_src2_rdy,
   output logic [N_ENTRIES-1:0]           deq_sel_onehot,
   output logic                           deq_ready,
   output logic [TAG_WIDTH-1:0]           issue_dst_tag,
   output logic                           self_wakeup_valid,
   output logic [TAG_WIDTH-1:0]           self_wakeup_tag
);

   localparam int unsigned IdxW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

   logic [CTR_WIDTH-1:0] count_clamped;
   logic [N_ENTRIES-1:0] valid, match1, match2, cand;
   logic [IdxW-1:0]      sel_idx;
   logic                 found;
   logic                 can_issue;
   logic [LAT_WIDTH-1:0] issue_lat;

   logic [LAT_WIDTH-1:0] busy_q, busy_d;
   logic [TAG_WIDTH-1:0] pend_tag_q, pend_tag_d;
   logic                 swk_valid_q, swk_valid_d;
   logic [TAG_WIDTH-1:0] swk_tag_q, swk_tag_d;

   // Occupancy decode, wakeup tag match and oldest-ready selection
   always_comb begin
      count_clamped = (entry_count > CTR_WIDTH'(N_ENTRIES)) ? CTR_WIDTH'(N_ENTRIES) : entry_count;
      valid   = '0;
      match1  = '0;
      match2  = '0;
      cand    = '0;
      sel_idx = '0;
      found   = 1'b0;
      for (int i = 0; i < N_ENTRIES; i++) begin
         valid[i] = (CTR_WIDTH'(i) < count_clamped);
         for (int k = 0; k < N_WAKEUP; k++) begin
            if (wakeup_valid[k] &&
                wakeup_tag[k*TAG_WIDTH +: TAG_WIDTH] == entry_src1_tag[i*TAG_WIDTH +: TAG_WIDTH])
               match1[i] = valid[i];
            if (wakeup_valid[k] &&
                wakeup_tag[k*TAG_WIDTH +: TAG_WIDTH] == entry_src2_tag[i*TAG_WIDTH +: TAG_WIDTH])
               match2[i] = valid[i];
         end
         // Same-cycle bypass: a source woken this cycle counts as ready
         cand[i] = valid[i] && (entry_src1_rdy[i] || match1[i]) && (entry_src2_rdy[i] || match2[i]);
      end
      for (int i = 0; i < N_ENTRIES; i++) begin
         if (cand[i] && !found) begin
            found   = 1'b1;
            sel_idx = IdxW'(i);
         end
      end
   end

   // Issue handshake and ready-bit write-back; everything quiet during reset
   always_comb begin
      can_issue      = !rst && !flush && (busy_q == '0) && fu_ready && found;
      deq_ready      = can_issue;
      deq_sel_onehot = can_issue ? (N_ENTRIES'(1) << sel_idx) : '0;
      issue_dst_tag  = can_issue ? entry_dst_tag[sel_idx*TAG_WIDTH +: TAG_WIDTH] : '0;
      issue_lat      = entry_lat[sel_idx*LAT_WIDTH +: LAT_WIDTH];
      set_src1_rdy   = rst ? '0 : (match1 & ~entry_src1_rdy);
      set_src2_rdy   = rst ? '0 : (match2 & ~entry_src2_rdy);
      // The issuing entry leaves the queue, so writing its ready bits is pointless
      rdy_wr_en      = (rst || flush) ? '0 : ((set_src1_rdy | set_src2_rdy) & ~deq_sel_onehot);
   end

   // Busy countdown and self-wakeup next state
   always_comb begin
      busy_d      = busy_q;
      pend_tag_d  = pend_tag_q;
      swk_valid_d = 1'b0;
      swk_tag_d   = swk_tag_q;
      if (busy_q != '0) begin
         busy_d = busy_q - LAT_WIDTH'(1);
         if (busy_q == LAT_WIDTH'(1)) begin
            swk_valid_d = 1'b1;
            swk_tag_d   = pend_tag_q;
         end
      end
      if (can_issue) begin
         if (issue_lat == '0) begin
            swk_valid_d = 1'b1;
            swk_tag_d   = issue_dst_tag;
         end else begin
            busy_d     = issue_lat;
            pend_tag_d = issue_dst_tag;
         end
      end
      // Flush kills the in-flight op and any wakeup it would produce
      if (flush) begin
         busy_d      = '0;
         swk_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q      <= '0;
         pend_tag_q  <= '0;
         swk_valid_q <= 1'b0;
         swk_tag_q   <= '0;
      end else begin
         busy_q      <= busy_d;
         pend_tag_q  <= pend_tag_d;
         swk_valid_q <= swk_valid_d;
         swk_tag_q   <= swk_tag_d;
      end
   end

   assign self_wakeup_valid = swk_valid_q;
   assign self_wakeup_tag   = swk_tag_q;

endmodule

// File: tb/tb_iq_issue_sched.sv
// Directed bench for iq_issue_sched: comb outputs checked each step, self
// wakeups checked against a scoreboard of expected (cycle, tag) pairs.
module tb_iq_issue_sched;

   localparam int N  = 8;
   localparam int TW = 6;
   localparam int NW = 2;
   localparam int LW = 3;
   localparam int CW = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            flush = 1'b0;
   logic [CW-1:0]   entry_count = '0;
   logic [N*TW-1:0] entry_src1_tag = '0, entry_src2_tag = '0, entry_dst_tag = '0;
   logic [N-1:0]    entry_src1_rdy = '0, entry_src2_rdy = '0;
   logic [N*LW-1:0] entry_lat = '0;
   logic [NW-1:0]   wakeup_valid = '0;
   logic [NW*TW-1:0] wakeup_tag = '0;
   logic            fu_ready = 1'b0;
   logic [N-1:0]    rdy_wr_en, set_src1_rdy, set_src2_rdy, deq_sel_onehot;
   logic            deq_ready, self_wakeup_valid;
   logic [TW-1:0]   issue_dst_tag, self_wakeup_tag;

   iq_issue_sched dut (
      .clk               (clk),
      .rst               (rst),
      .flush             (flush),
      .entry_count       (entry_count),
      .entry_src1_tag    (entry_src1_tag),
      .entry_src2_tag    (entry_src2_tag),
      .entry_src1_rdy    (entry_src1_rdy),
      .entry_src2_rdy    (entry_src2_rdy),
      .entry_dst_tag     (entry_dst_tag),
      .entry_lat         (entry_lat),
      .wakeup_valid      (wakeup_valid),
      .wakeup_tag        (wakeup_tag),
      .fu_ready          (fu_ready),
      .rdy_wr_en         (rdy_wr_en),
      .set_src1_rdy      (set_src1_rdy),
      .set_src2_rdy      (set_src2_rdy),
      .deq_sel_onehot    (deq_sel_onehot),
      .deq_ready         (deq_ready),
      .issue_dst_tag     (issue_dst_tag),
      .self_wakeup_valid (self_wakeup_valid),
      .self_wakeup_tag   (self_wakeup_tag)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int            at;
      logic [TW-1:0] tag;
   } wk_t;
   wk_t sb[$];

   // Queue model and control inputs, applied by drive()
   logic [TW-1:0] m_s1t[N], m_s2t[N], m_dst[N];
   logic          m_r1[N], m_r2[N];
   logic [LW-1:0] m_lat[N];
   int            m_cnt;
   logic          m_rst, m_flush, m_fu;
   logic [NW-1:0] m_wv;
   logic [NW*TW-1:0] m_wt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic expect_wk(input int at, input logic [TW-1:0] tag);
      wk_t w;
      w.at  = at;
      w.tag = tag;
      sb.push_back(w);
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         entry_src1_tag[i*TW +: TW] = m_s1t[i];
         entry_src2_tag[i*TW +: TW] = m_s2t[i];
         entry_dst_tag[i*TW +: TW]  = m_dst[i];
         entry_src1_rdy[i]          = m_r1[i];
         entry_src2_rdy[i]          = m_r2[i];
         entry_lat[i*LW +: LW]      = m_lat[i];
      end
      entry_count  = CW'(m_cnt);
      rst          = m_rst;
      flush        = m_flush;
      fu_ready     = m_fu;
      wakeup_valid = m_wv;
      wakeup_tag   = m_wt;
   endtask

   // Advance one cycle, apply inputs after the edge, settle before checks
   task automatic tick();
      @(posedge clk);
      #1 drive();
      #3;
   endtask

   task automatic set_entry(input int i, input logic [TW-1:0] s1t, input logic r1,
                            input logic [TW-1:0] s2t, input logic r2,
                            input logic [TW-1:0] dst, input logic [LW-1:0] lat);
      m_s1t[i] = s1t; m_r1[i] = r1; m_s2t[i] = s2t; m_r2[i] = r2;
      m_dst[i] = dst; m_lat[i] = lat;
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) set_entry(i, 6'd63, 1'b0, 6'd62, 1'b0, 6'd0, 3'd0);
      m_cnt = 0;
   endtask

   // Model the fifo_ram collapse after an issue from index 0
   task automatic collapse();
      for (int i = 0; i < N - 1; i++)
         set_entry(i, m_s1t[i+1], m_r1[i+1], m_s2t[i+1], m_r2[i+1], m_dst[i+1], m_lat[i+1]);
      set_entry(N - 1, 6'd63, 1'b0, 6'd62, 1'b0, 6'd0, 3'd0);
      m_cnt--;
   endtask

   // Self-wakeup monitor: pulse only when the scoreboard expects one
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].at == cyc) begin
         chk("wk_valid", 32'(self_wakeup_valid), 32'd1);
         chk("wk_tag", 32'(self_wakeup_tag), 32'(sb[0].tag));
         void'(sb.pop_front());
      end else begin
         chk("wk_idle", 32'(self_wakeup_valid), 32'd0);
      end
   end

   initial begin
      clear_all();
      m_rst = 1'b1; m_flush = 1'b0; m_fu = 1'b1; m_wv = '0; m_wt = '0;

      // Reset with ready entries present: all outputs forced low
      for (int i = 0; i < 3; i++) set_entry(i, 6'd1, 1'b1, 6'd2, 1'b1, 6'(10 + i), 3'd0);
      m_cnt = 3;
      tick();
      chk("rst_deq_ready", 32'(deq_ready), 32'd0);
      chk("rst_deq_sel", 32'(deq_sel_onehot), 32'd0);
      chk("rst_dst", 32'(issue_dst_tag), 32'd0);
      chk("rst_wr_en", 32'(rdy_wr_en), 32'd0);

      // Back-to-back pipelined issue from the head of a collapsing queue
      m_rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("b2b_sel", 32'(deq_sel_onehot), 32'h1);
         chk("b2b_ready", 32'(deq_ready), 32'd1);
         chk("b2b_dst", 32'(issue_dst_tag), 32'(10 + k));
         expect_wk(cyc + 1, 6'(10 + k));
         collapse();
      end
      tick();
      chk("empty_ready", 32'(deq_ready), 32'd0);

      // Wakeup bypass and write-back
      clear_all();
      set_entry(0, 6'd5, 1'b0, 6'd7, 1'b1, 6'd20, 3'd0);
      set_entry(1, 6'd5, 1'b1, 6'd8, 1'b1, 6'd21, 3'd0);
      set_entry(2, 6'd5, 1'b0, 6'd5, 1'b0, 6'd22, 3'd0);
      m_cnt = 2;
      tick();
      chk("nowk_sel", 32'(deq_sel_onehot), 32'h2);
      chk("nowk_dst", 32'(issue_dst_tag), 32'd21);
      chk("nowk_wr_en", 32'(rdy_wr_en), 32'd0);
      expect_wk(cyc + 1, 6'd21);
      m_wv = 2'b10; m_wt = {6'd5, 6'd0};
      tick();
      chk("byp_sel", 32'(deq_sel_onehot), 32'h1);
      chk("byp_dst", 32'(issue_dst_tag), 32'd20);
      chk("byp_wr_en", 32'(rdy_wr_en), 32'd0);
      chk("byp_set1", 32'(set_src1_rdy), 32'h1);
      expect_wk(cyc + 1, 6'd20);
      m_fu = 1'b0; m_wv = 2'b11; m_wt = {6'd5, 6'd5};
      tick();
      chk("wb_ready", 32'(deq_ready), 32'd0);
      chk("wb_wr_en", 32'(rdy_wr_en), 32'h1);
      chk("wb_set1", 32'(set_src1_rdy), 32'h1);
      chk("wb_set2", 32'(set_src2_rdy), 32'h0);

      // FU back-pressure then release
      m_wv = '0;
      tick();
      chk("fu_hold_ready", 32'(deq_ready), 32'd0);
      chk("fu_hold_sel", 32'(deq_sel_onehot), 32'd0);
      m_fu = 1'b1;
      tick();
      chk("fu_rise_ready", 32'(deq_ready), 32'd1);
      chk("fu_rise_sel", 32'(deq_sel_onehot), 32'h2);
      expect_wk(cyc + 1, 6'd21);

      // entry_count clamping
      clear_all();
      set_entry(7, 6'd1, 1'b1, 6'd2, 1'b1, 6'd60, 3'd0);
      m_cnt = 15;
      tick();
      chk("clamp_sel", 32'(deq_sel_onehot), 32'h80);
      chk("clamp_dst", 32'(issue_dst_tag), 32'd60);
      expect_wk(cyc + 1, 6'd60);
      m_cnt = 7;
      tick();
      chk("cnt7_ready", 32'(deq_ready), 32'd0);
      m_cnt = 8;
      tick();
      chk("cnt8_sel", 32'(deq_sel_onehot), 32'h80);
      expect_wk(cyc + 1, 6'd60);

      // Multi-cycle op blocks issue until its wakeup
      clear_all();
      set_entry(0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd9, 3'd3);
      set_entry(1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd30, 3'd0);
      m_cnt = 2;
      tick();
      chk("lat_sel", 32'(deq_sel_onehot), 32'h1);
      chk("lat_dst", 32'(issue_dst_tag), 32'd9);
      expect_wk(cyc + 4, 6'd9);
      collapse();
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("busy_block", 32'(deq_ready), 32'd0);
      end
      tick();
      chk("busy_done_ready", 32'(deq_ready), 32'd1);
      chk("busy_done_dst", 32'(issue_dst_tag), 32'd30);
      expect_wk(cyc + 1, 6'd30);
      collapse();

      // Flush during a busy period cancels it and blocks write-back
      clear_all();
      set_entry(0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd40, 3'd2);
      set_entry(1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd41, 3'd0);
      m_cnt = 2;
      tick();
      chk("fl_issue_dst", 32'(issue_dst_tag), 32'd40);
      collapse();
      m_s1t[0] = 6'd3; m_r1[0] = 1'b0;
      m_flush = 1'b1; m_wv = 2'b01; m_wt = {6'd0, 6'd3};
      tick();
      chk("fl_ready", 32'(deq_ready), 32'd0);
      chk("fl_wr_en", 32'(rdy_wr_en), 32'd0);
      m_flush = 1'b0; m_wv = '0; m_r1[0] = 1'b1;
      tick();
      chk("post_fl_ready", 32'(deq_ready), 32'd1);
      chk("post_fl_dst", 32'(issue_dst_tag), 32'd41);
      expect_wk(cyc + 1, 6'd41);
      collapse();
      tick();
      tick();

      // Reset in the middle of a busy period
      clear_all();
      set_entry(0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd50, 3'd3);
      set_entry(1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd51, 3'd0);
      m_cnt = 2;
      tick();
      chk("rb_issue_dst", 32'(issue_dst_tag), 32'd50);
      collapse();
      tick();
      chk("rb_busy", 32'(deq_ready), 32'd0);
      m_rst = 1'b1;
      tick();
      chk("rb_rst_ready", 32'(deq_ready), 32'd0);
      chk("rb_rst_sel", 32'(deq_sel_onehot), 32'd0);
      chk("rb_rst_dst", 32'(issue_dst_tag), 32'd0);
      m_rst = 1'b0;
      tick();
      chk("rb_after_ready", 32'(deq_ready), 32'd1);
      chk("rb_after_dst", 32'(issue_dst_tag), 32'd51);
      expect_wk(cyc + 1, 6'd51);
      collapse();
      for (int k = 0; k < 4; k++) tick();

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
